// File: rtl/d_e_pipe_reg.sv
// Decode-to-Execute pipeline register with bubble insertion, freeze hold and Tnew ageing.
// Optional DE_BUBBLE_CNT_EN adds a saturating 16-bit count of inserted bubbles.
module d_e_pipe_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        E_freeze,
  input  logic [31:0] D_pc,
  input  logic [31:0] D_instr,
  input  logic [31:0] D_rs_data,
  input  logic [31:0] D_rt_data,
  input  logic [31:0] D_imme32,
  input  logic [4:0]  D_wa,
  input  logic [1:0]  D_tnew,
  output logic [31:0] E_pc,
  output logic [31:0] E_instr,
  output logic [31:0] E_rs_data,
  output logic [31:0] E_rt_data,
  output logic [31:0] E_imme32,
  output logic [4:0]  E_wa,
  output logic [1:0]  E_tnew,
  output logic        E_bubble
`ifdef DE_BUBBLE_CNT_EN
  ,
  output logic [15:0] E_bubble_cnt
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] rs_data_q, rs_data_d;
  logic [31:0] rt_data_q, rt_data_d;
  logic [31:0] imme32_q, imme32_d;
  logic [4:0]  wa_q, wa_d;
  logic [1:0]  tnew_q, tnew_d;
  logic        bubble_q, bubble_d;
  logic        load_bubble;

  // Freeze outranks stall, so a bubble is only inserted on an unfrozen edge.
  assign load_bubble = stall && !E_freeze;

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imme32_d  = imme32_q;
    wa_d      = wa_q;
    tnew_d    = tnew_q;
    bubble_d  = bubble_q;
    if (E_freeze) begin
      bubble_d = bubble_q;
    end else if (stall) begin
      pc_d      = D_pc;
      instr_d   = 32'h0;
      rs_data_d = 32'h0;
      rt_data_d = 32'h0;
      imme32_d  = 32'h0;
      wa_d      = 5'd0;
      tnew_d    = 2'd0;
      bubble_d  = 1'b1;
    end else begin
      pc_d      = D_pc;
      instr_d   = D_instr;
      rs_data_d = D_rs_data;
      rt_data_d = D_rt_data;
      imme32_d  = D_imme32;
      wa_d      = D_wa;
      // Entering Execute consumes one Tnew cycle; never underflow below zero.
      tnew_d    = (D_tnew == 2'd0) ? 2'd0 : D_tnew - 2'd1;
      bubble_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0;
      rs_data_q <= 32'h0;
      rt_data_q <= 32'h0;
      imme32_q  <= 32'h0;
      wa_q      <= 5'd0;
      tnew_q    <= 2'd0;
      bubble_q  <= 1'b1;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imme32_q  <= imme32_d;
      wa_q      <= wa_d;
      tnew_q    <= tnew_d;
      bubble_q  <= bubble_d;
    end
  end

  assign E_pc      = pc_q;
  assign E_instr   = instr_q;
  assign E_rs_data = rs_data_q;
  assign E_rt_data = rt_data_q;
  assign E_imme32  = imme32_q;
  assign E_wa      = wa_q;
  assign E_tnew    = tnew_q;
  assign E_bubble  = bubble_q;

`ifdef DE_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (load_bubble && bubble_cnt_q != 16'hFFFF) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= 16'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign E_bubble_cnt = bubble_cnt_q;
`else
  logic unused_load_bubble;
  assign unused_load_bubble = load_bubble;
`endif

endmodule
